// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and the preset register.
package keypad_pkg;

    localparam int COL_W = 4;

    localparam logic [3:0] KEY_CLR = 4'd10;
    localparam logic [3:0] KEY_ENT = 4'd11;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } scan_state_e;

    // When several rows read low at once, the lowest row index is reported.
    function automatic logic [1:0] lowest_low_row(input logic [COL_W-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = COL_W - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_preset_if.sv
// Matrix pins plus the key/preset outputs of the keypad preset block.
interface keypad_preset_if;
    import keypad_pkg::*;

    logic [COL_W-1:0] row_in;
    logic [COL_W-1:0] col_out;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [3:0]       preset0;
    logic [3:0]       preset1;
    logic [3:0]       preset2;
    logic [3:0]       preset3;
    logic             preset_load;

    modport master (
        input  row_in,
        output col_out, key_valid, key_code,
        output preset0, preset1, preset2, preset3, preset_load
    );

    modport slave (
        output row_in,
        input  col_out, key_valid, key_code,
        input  preset0, preset1, preset2, preset3, preset_load
    );

endinterface

// File: rtl/keypad_matrix_scan.sv
// Column scanner with row synchronizer, dwell timer and press/release debounce.
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COL_W-1:0] row_in,
    output logic [COL_W-1:0] col_out,
    output logic             key_valid,
    output logic [3:0]       key_code,
    output logic             accept,
    output logic [3:0]       accept_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);
    localparam logic [COL_W-1:0] ALL_HIGH  = '1;

    logic [COL_W-1:0] sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    scan_state_e      state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [COL_W-1:0] col_out_q, col_out_d;
    logic [COL_W-1:0] pat_q, pat_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q;
    logic             sample;

    // cnt counts matching presses in DEBOUNCE and consecutive releases in HELD.
    always_comb begin
        sample      = (div_q == DIV_LAST);
        div_d       = sample ? '0 : div_q + DIV_W'(1);
        state_d     = state_q;
        col_d       = col_q;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        accept_code = {lowest_low_row(pat_q), col_q};

        unique case (state_q)
            SCAN: begin
                if (sample) begin
                    if (sync2_q == ALL_HIGH) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        pat_d   = sync2_q;
                        cnt_d   = DB_W'(1);
                        state_d = DEBOUNCE;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept      = 1'b1;
                            accept_code = {lowest_low_row(sync2_q), col_q};
                        end
                    end
                end
            end
            DEBOUNCE: begin
                if (DEBOUNCE_SCANS == 1) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (sample) begin
                    if (sync2_q != pat_q) begin
                        state_d = SCAN;
                    end else if (cnt_q + DB_W'(1) == DB_TARGET) begin
                        accept  = 1'b1;
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
            end
            HELD: begin
                if (sample) begin
                    if (sync2_q != ALL_HIGH) begin
                        cnt_d = '0;
                    end else if (cnt_q + DB_W'(1) == DB_TARGET) begin
                        cnt_d   = '0;
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        col_out_d = ~(COL_W'(1) << col_d);
        code_d    = accept ? accept_code : code_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            div_q     <= '0;
            state_q   <= SCAN;
            col_q     <= 2'd0;
            col_out_q <= 4'b1110;
            pat_q     <= '1;
            cnt_q     <= '0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= row_in;
            sync2_q   <= sync1_q;
            div_q     <= div_d;
            state_q   <= state_d;
            col_q     <= col_d;
            col_out_q <= col_out_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= accept;
        end
    end

    assign col_out   = col_out_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;

endmodule

// File: rtl/keypad_preset.sv
// Keypad front end: digit keys shift into a 4-digit BCD preset, CLR zeroes it, ENT loads it.
module keypad_preset
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic             clk,
    input logic             rst_n,
    keypad_preset_if.master bus
);

    logic             accept;
    logic [3:0]       accept_code;
    logic [3:0][3:0]  preset_q, preset_d;
    logic             preset_load_q, preset_load_d;

    keypad_matrix_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_in     (bus.row_in),
        .col_out    (bus.col_out),
        .key_valid  (bus.key_valid),
        .key_code   (bus.key_code),
        .accept     (accept),
        .accept_code(accept_code)
    );

    // Acting on the pre-register accept keeps presets aligned with key_valid.
    always_comb begin
        preset_d      = preset_q;
        preset_load_d = 1'b0;
        if (accept) begin
            if (accept_code < KEY_CLR) begin
                preset_d[0] = preset_q[1];
                preset_d[1] = preset_q[2];
                preset_d[2] = preset_q[3];
                preset_d[3] = accept_code;
            end else if (accept_code == KEY_CLR) begin
                preset_d = '0;
            end else if (accept_code == KEY_ENT) begin
                preset_load_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset_q      <= '0;
            preset_load_q <= 1'b0;
        end else begin
            preset_q      <= preset_d;
            preset_load_q <= preset_load_d;
        end
    end

    assign bus.preset0     = preset_q[0];
    assign bus.preset1     = preset_q[1];
    assign bus.preset2     = preset_q[2];
    assign bus.preset3     = preset_q[3];
    assign bus.preset_load = preset_load_q;

endmodule

// File: tb/tb_keypad_preset.sv
// Directed bench for keypad_preset; the key matrix is modelled from col_out.
module tb_keypad_preset;
    import keypad_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    keypad_preset_if bus ();

    keypad_preset #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Pressed rows appear on row_in only while their column is driven low.
    logic [3:0] key_rows = 4'hF;
    logic [1:0] key_col  = 2'd0;
    always_comb bus.row_in = (bus.col_out[key_col] == 1'b0) ? key_rows : 4'hF;

    int checks        = 0;
    int errors        = 0;
    int kv_count      = 0;
    int pl_count      = 0;
    int pl_misaligned = 0;
    int base;
    int n;
    logic [3:0] prev_col;

    always @(posedge clk) begin
        #1;
        if (bus.key_valid) kv_count++;
        if (bus.preset_load) begin
            pl_count++;
            if (!(bus.key_valid && bus.key_code == KEY_ENT)) pl_misaligned++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_kv(input int target, input string tag);
        int k;
        k = 0;
        while (kv_count < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, 16'(kv_count >= target), 16'd1);
    endtask

    task automatic press_key(input int r, input int c, input int hold);
        key_col  = 2'(c);
        key_rows = ~(4'(1) << r);
        repeat (hold) @(negedge clk);
        key_rows = 4'hF;
        repeat (32) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset values and exact column dwell.
        repeat (3) @(negedge clk);
        check("rst_col", 16'(bus.col_out), 16'h000E);
        check("rst_kv", 16'(bus.key_valid), 16'd0);
        check("rst_code", 16'(bus.key_code), 16'd0);
        check("rst_presets", {bus.preset0, bus.preset1, bus.preset2, bus.preset3}, 16'h0000);
        check("rst_load", 16'(bus.preset_load), 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("dwell_col0", 16'(bus.col_out), 16'h000E);
        @(negedge clk);
        check("dwell_col1", 16'(bus.col_out), 16'h000D);

        // Key 6 held for 40 cycles, then released.
        base     = kv_count;
        key_col  = 2'd2;
        key_rows = 4'b1101;
        repeat (40) @(negedge clk);
        check("hold_kv_count", 16'(kv_count - base), 16'd1);
        check("hold_code", 16'(bus.key_code), 16'd6);
        check("hold_preset3", 16'(bus.preset3), 16'd6);
        check("hold_col_parked", 16'(bus.col_out), 16'h000B);
        key_rows = 4'hF;
        n = 0;
        while (bus.col_out == 4'b1011 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("release_delay", 16'(n >= 9 && n <= 14), 16'd1);
        check("release_next_col", 16'(bus.col_out), 16'h0007);
        check("hold_no_repeat", 16'(kv_count - base), 16'd1);

        // 0, 3, 0, ENT from a cleared preset.
        pulse_reset();
        base = kv_count;
        press_key(0, 0, 48);
        press_key(0, 3, 48);
        press_key(0, 0, 48);
        check("pre_ent_load", 16'(pl_count), 16'd0);
        press_key(2, 3, 48);
        check("ent_kv_count", 16'(kv_count - base), 16'd4);
        check("ent_code", 16'(bus.key_code), 16'd11);
        check("ent_preset0", 16'(bus.preset0), 16'd0);
        check("ent_preset1", 16'(bus.preset1), 16'd0);
        check("ent_preset2", 16'(bus.preset2), 16'd3);
        check("ent_preset3", 16'(bus.preset3), 16'd0);
        check("ent_load_count", 16'(pl_count), 16'd1);
        check("ent_load_aligned", 16'(pl_misaligned), 16'd0);

        // Digits 1..5 overflow the register, then CLR.
        press_key(0, 1, 48);
        press_key(0, 2, 48);
        press_key(0, 3, 48);
        press_key(1, 0, 48);
        press_key(1, 1, 48);
        check("five_digits", {bus.preset0, bus.preset1, bus.preset2, bus.preset3}, 16'h2345);
        press_key(2, 2, 48);
        check("clr_code", 16'(bus.key_code), 16'd10);
        check("clr_presets", {bus.preset0, bus.preset1, bus.preset2, bus.preset3}, 16'h0000);
        check("clr_no_load", 16'(pl_count), 16'd1);

        // Key 5 bounces: low, high, then steady low, aligned to column 1 dwells.
        base     = kv_count;
        key_col  = 2'd1;
        key_rows = 4'hF;
        prev_col = bus.col_out;
        n        = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.col_out == 4'b1101 && prev_col != 4'b1101) break;
            prev_col = bus.col_out;
        end
        check("bounce_align", 16'(n < 40), 16'd1);
        key_rows = 4'b1101;
        repeat (4) @(negedge clk);
        key_rows = 4'hF;
        repeat (4) @(negedge clk);
        key_rows = 4'b1101;
        repeat (11) @(negedge clk);
        check("bounce_no_early_kv", 16'(kv_count - base), 16'd0);
        check("bounce_kv_low", 16'(bus.key_valid), 16'd0);
        @(negedge clk);
        check("bounce_kv_high", 16'(bus.key_valid), 16'd1);
        check("bounce_code", 16'(bus.key_code), 16'd5);
        repeat (20) @(negedge clk);
        key_rows = 4'hF;
        repeat (32) @(negedge clk);
        check("bounce_kv_count", 16'(kv_count - base), 16'd1);
        check("bounce_preset3", 16'(bus.preset3), 16'd5);

        // Rows 0 and 2 low together on column 1.
        base     = kv_count;
        key_col  = 2'd1;
        key_rows = 4'b1010;
        repeat (48) @(negedge clk);
        key_rows = 4'hF;
        repeat (32) @(negedge clk);
        check("multi_kv_count", 16'(kv_count - base), 16'd1);
        check("multi_code", 16'(bus.key_code), 16'd1);
        check("multi_presets", {bus.preset0, bus.preset1, bus.preset2, bus.preset3}, 16'h0051);

        // Reset while key 7 is held, then release reset with the key still down.
        base     = kv_count;
        key_col  = 2'd3;
        key_rows = 4'b1101;
        wait_kv(base + 1, "k7_timeout");
        repeat (6) @(negedge clk);
        check("k7_code", 16'(bus.key_code), 16'd7);
        check("k7_presets", {bus.preset0, bus.preset1, bus.preset2, bus.preset3}, 16'h0517);
        rst_n = 1'b0;
        #1;
        check("mid_rst_col", 16'(bus.col_out), 16'h000E);
        check("mid_rst_kv", 16'(bus.key_valid), 16'd0);
        check("mid_rst_code", 16'(bus.key_code), 16'd0);
        check("mid_rst_presets", {bus.preset0, bus.preset1, bus.preset2, bus.preset3}, 16'h0000);
        check("mid_rst_load", 16'(bus.preset_load), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = kv_count;
        wait_kv(base + 1, "k7_again_timeout");
        @(negedge clk);
        check("k7_again_code", 16'(bus.key_code), 16'd7);
        check("k7_again_preset3", 16'(bus.preset3), 16'd7);
        repeat (30) @(negedge clk);
        check("k7_again_once", 16'(kv_count - base), 16'd1);
        key_rows = 4'hF;
        repeat (32) @(negedge clk);
        check("k7_final_count", 16'(kv_count - base), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_preset.md
# keypad_preset

Scans a 4x4 active-low key matrix, debounces each press, and reports one key code per press. Digit keys are assembled into a 4-digit BCD preset register that feeds the countdown counter's `in0`..`in3` loads in place of hard-wired constants. It is the input-side counterpart of the display scanner: it drives columns and reads rows, where the display scanner drives digits and segments.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per column dwell; the row sample is taken on the last cycle of each dwell. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: number of consecutive matching samples required to accept a press or a release. Must be ≥ 1.
- `clk` input 1: single clock for the whole block.
- `rst_n` input 1: asynchronous, active-low reset.
- `row_in` input 4: matrix rows, active-low and externally pulled up; asynchronous to `clk`.
- `col_out` output 4: matrix columns, active-low, one-hot-low.
- `key_valid` output 1: one-cycle pulse, one per accepted press.
- `key_code` output 4: code of the last accepted key, computed as 4·row+col; holds its value between presses.
- `preset0`..`preset3` output 4 each: BCD preset digits; `preset0` is the most significant digit and `preset3` the least.
- `preset_load` output 1: one-cycle pulse when the enter key is accepted.

## Operation
- `row_in` passes through a 2-FF synchronizer. All samples use the synchronized value.
- Scan FSM states and transitions:
  - SCAN: drive column `c` low for `SCAN_DIV` cycles, then sample. If all rows are high, set c ← (c+1) mod 4 and stay in SCAN. Otherwise latch the row pattern, set dbcnt=1, and go to DEBOUNCE.
  - DEBOUNCE: keep column `c` driven. Each sample equal to the latched pattern increments dbcnt. When dbcnt reaches `DEBOUNCE_SCANS`, accept the key and go to HELD. Any different sample, including all-high, returns to SCAN on the same column.
  - HELD: keep column `c` driven and count consecutive all-high samples. Any low sample resets that count. When the count reaches `DEBOUNCE_SCANS`, advance the column and go to SCAN.
- Multiple rows low: the lowest row index wins. The full pattern is still used for the DEBOUNCE comparison.
- Key codes:
  - 0–9: digits.
  - 10 (CLR): sets all presets to 0.
  - 11 (ENT): pulses `preset_load`.
  - 12–15: reported on `key_code` and `key_valid`, with no effect on presets.
- Digit accept: presets shift left (`preset0`←`preset1`, `preset1`←`preset2`, `preset2`←`preset3`, `preset3`←digit). The oldest digit is discarded.
- A key held indefinitely produces exactly one `key_valid`. There is no auto-repeat.
- With `DEBOUNCE_SCANS`=1, a press is accepted on its first low sample. The block passes through DEBOUNCE for one cycle.
- Reset values: `col_out`=4'b1110 (column 0), state SCAN, dwell counter 0, `key_valid`=0, `key_code`=0, all presets 0, `preset_load`=0, synchronizer flops 1.
- Reset asserted mid-press: the block returns to the reset state immediately. After release of reset, a still-held key is detected again and reported once.

## Timing
- Each column dwell is exactly `SCAN_DIV` cycles, so a full matrix sweep takes 4·`SCAN_DIV` cycles.
- `key_valid`, `key_code`, the preset update and `preset_load` are all registered and change on the same edge: the edge after the accepting sample cycle.
- Latency from a synchronized stable press (found in SCAN) to `key_valid`: (`DEBOUNCE_SCANS`−1)·`SCAN_DIV` + 1 cycles after the first low sample.
- Synchronizer latency is 2 cycles. Row changes within 2 cycles of a sample edge may fall into the next dwell.
- `preset0`..`preset3` are stable except on accept edges. The consumer may sample them on `preset_load`.

## Structure
- Shared package `keypad_pkg`:
  - Scan FSM state enum (SCAN, DEBOUNCE, HELD).
  - Key-code constants KEY_CLR=10 and KEY_ENT=11.
  - Column width constant (4).
- Sub-module `keypad_matrix_scan` contains the synchronizer, the dwell counter and the scan FSM. It outputs `col_out`, `key_valid` and `key_code`.
- The `keypad_preset` top instantiates `keypad_matrix_scan` and holds the preset shift register and `preset_load` logic.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=3; the bench models the matrix from `col_out`.
- Hold key (row 1, col 2) for 40 cycles, then release → exactly one `key_valid` with `key_code`=6; `preset3`=6; `col_out` resumes rotating after 3 all-high samples.
- Press keys 0, 3, 0, then ENT (key 11) → presets read 0,0,3,0 (`preset0`..`preset3`); `preset_load` pulses once, on the same edge as ENT's `key_valid`.
- Enter 1,2,3,4,5, then CLR → after the fifth digit presets read 2,3,4,5; after CLR they read 0,0,0,0; no `preset_load` pulse.
- Key 5 bounces (low for one sample, high for one, low again) then stays low → no `key_valid` until 3 consecutive low samples; then exactly one pulse with `key_code`=5.
- Rows 0 and 2 low together on column 1 → `key_code`=1 (lowest row wins); one pulse.
- Assert `rst_n` low while HELD with key 7 → `col_out`=4'b1110 and all outputs at reset values immediately; release reset with key still held → one new `key_valid` with code 7 after debounce.
